// File: rtl/reorder_tagger.sv
// Upstream companion of the reorder queue: tags in-order requests with the queue's index tag and
// forwards them, registers tagged responses into the queue. Optional checking: REORDER_TAGGER_ERR_EN.
module reorder_tagger #(
  parameter int DEPTH         = 32,
  parameter int TAG_WIDTH     = 6,
  parameter int REQ_WIDTH     = 32,
  parameter int PAYLOAD_WIDTH = 8,
  parameter int INIT_CYCLES   = DEPTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic [REQ_WIDTH-1:0]               req_data,
  output logic                               mem_req_valid,
  input  logic                               mem_req_stall,
  output logic [REQ_WIDTH-1:0]               mem_req_data,
  output logic [TAG_WIDTH-1:0]               mem_req_tag,
  input  logic                               mem_rsp_valid,
  input  logic [TAG_WIDTH-1:0]               mem_rsp_tag,
  input  logic [PAYLOAD_WIDTH-1:0]           mem_rsp_data,
  output logic                               rq_increment,
  input  logic [TAG_WIDTH-1:0]               rq_index_tag,
  input  logic                               rq_full,
  output logic                               rq_wr_en,
  output logic [PAYLOAD_WIDTH+TAG_WIDTH-1:0] rq_d,
  output logic [TAG_WIDTH-1:0]               outstanding,
  output logic                               busy
`ifdef REORDER_TAGGER_ERR_EN
  ,
  output logic                               tag_err
`endif
);

  localparam int CNT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);
  localparam logic [TAG_WIDTH-1:0] DEPTH_TAG = TAG_WIDTH'(DEPTH);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                              state_reg, state_next;
  logic [CNT_W-1:0]                    init_cnt_reg;
  logic [TAG_WIDTH-1:0]                outstanding_reg, outstanding_next;
  logic                                mem_req_valid_reg;
  logic [REQ_WIDTH-1:0]                mem_req_data_reg;
  logic [TAG_WIDTH-1:0]                mem_req_tag_reg;
  logic                                rq_wr_en_reg;
  logic [PAYLOAD_WIDTH+TAG_WIDTH-1:0]  rq_d_reg;
  logic                                out_free;
  logic                                accept;

  // State register; the INIT counter covers the queue's occupancy sweep after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_INIT;
      init_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_INIT)
        init_cnt_reg <= init_cnt_reg + CNT_W'(1);
    end
  end

  // RUN is entered on the edge where the count reaches INIT_CYCLES.
  always_comb begin
    state_next = state_reg;
    if (state_reg == ST_INIT && init_cnt_reg == INIT_LAST)
      state_next = ST_RUN;
  end

  always_comb begin
    out_free     = !mem_req_valid_reg || !mem_req_stall;
    req_ready    = (state_reg == ST_RUN) && !rq_full && (outstanding_reg != DEPTH_TAG) && out_free;
    accept       = req_valid && req_ready;
    rq_increment = accept;
    busy         = (state_reg != ST_RUN) || (outstanding_reg != '0);
  end

  always_comb begin
    outstanding_next = outstanding_reg;
    if (accept && !mem_rsp_valid && outstanding_reg != DEPTH_TAG)
      outstanding_next = outstanding_reg + TAG_WIDTH'(1);
    else if (!accept && mem_rsp_valid && outstanding_reg != '0)
      outstanding_next = outstanding_reg - TAG_WIDTH'(1);
  end

  // A stalled request holds; an unstalled slot either reloads or empties.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req_valid_reg <= 1'b0;
      mem_req_data_reg  <= '0;
      mem_req_tag_reg   <= '0;
      rq_wr_en_reg      <= 1'b0;
      rq_d_reg          <= '0;
      outstanding_reg   <= '0;
    end else begin
      outstanding_reg <= outstanding_next;
      if (accept) begin
        mem_req_valid_reg <= 1'b1;
        mem_req_data_reg  <= req_data;
        mem_req_tag_reg   <= rq_index_tag;
      end else if (!mem_req_stall) begin
        mem_req_valid_reg <= 1'b0;
      end
      rq_wr_en_reg <= mem_rsp_valid;
      if (mem_rsp_valid)
        rq_d_reg <= {mem_rsp_data, mem_rsp_tag};
    end
  end

`ifdef REORDER_TAGGER_ERR_EN
  logic [TAG_WIDTH-1:0] rsp_dist;
  logic                 rsp_in_window;
  logic                 tag_err_reg;

  // A live tag sits 1..outstanding positions behind the queue's next index.
  always_comb begin
    rsp_dist      = rq_index_tag - mem_rsp_tag;
    rsp_in_window = (rsp_dist != '0) && (rsp_dist <= outstanding_reg);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      tag_err_reg <= 1'b0;
    else if (mem_rsp_valid && !rsp_in_window)
      tag_err_reg <= 1'b1;
  end

  assign tag_err = tag_err_reg;
`endif

  assign mem_req_valid = mem_req_valid_reg;
  assign mem_req_data  = mem_req_data_reg;
  assign mem_req_tag   = mem_req_tag_reg;
  assign rq_wr_en      = rq_wr_en_reg;
  assign rq_d          = rq_d_reg;
  assign outstanding   = outstanding_reg;

endmodule

// File: tb/tb_reorder_tagger.sv
// Directed bench for reorder_tagger: reset hold-off, tagging, stall, responses, saturation, reset.
module tb_reorder_tagger;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_data;
  logic        mem_req_valid;
  logic        mem_req_stall;
  logic [31:0] mem_req_data;
  logic [5:0]  mem_req_tag;
  logic        mem_rsp_valid;
  logic [5:0]  mem_rsp_tag;
  logic [7:0]  mem_rsp_data;
  logic        rq_increment;
  logic [5:0]  rq_index_tag;
  logic        rq_full;
  logic        rq_wr_en;
  logic [13:0] rq_d;
  logic [5:0]  outstanding;
  logic        busy;
`ifdef REORDER_TAGGER_ERR_EN
  logic        tag_err;
`endif

  int checks = 0;
  int errors = 0;

  reorder_tagger dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_data      (req_data),
    .mem_req_valid (mem_req_valid),
    .mem_req_stall (mem_req_stall),
    .mem_req_data  (mem_req_data),
    .mem_req_tag   (mem_req_tag),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_tag   (mem_rsp_tag),
    .mem_rsp_data  (mem_rsp_data),
    .rq_increment  (rq_increment),
    .rq_index_tag  (rq_index_tag),
    .rq_full       (rq_full),
    .rq_wr_en      (rq_wr_en),
    .rq_d          (rq_d),
    .outstanding   (outstanding),
    .busy          (busy)
`ifdef REORDER_TAGGER_ERR_EN
    ,
    .tag_err       (tag_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  initial begin
    logic [5:0] tag_v;
    rst = 1'b0;
    req_valid = 1'b1;
    req_data = 32'hA5A5A5A5;
    mem_req_stall = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_tag = '0;
    mem_rsp_data = '0;
    rq_index_tag = 6'd5;
    rq_full = 1'b0;
    tick();
    tick();
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_rq_wr_en", rq_wr_en, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_busy", busy, 1);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rq_increment", rq_increment, 0);
    chk("rst_mem_req_tag", mem_req_tag, 0);
    chk("rst_rq_d", rq_d, 0);
`ifdef REORDER_TAGGER_ERR_EN
    chk("rst_tag_err", tag_err, 0);
`endif

    // Hold-off: 32 cycles of req_ready=0 with req_valid held high
    rst = 1'b1;
    for (int i = 0; i < 32; i++) begin
      #1;
      chk($sformatf("init_ready_c%0d", i + 1), {req_ready, rq_increment}, 2'b00);
      tick();
    end
    #1;
    chk("c33_req_ready", req_ready, 1);
    chk("c33_rq_increment", rq_increment, 1);
    tick();
    req_valid = 1'b0;
    rq_index_tag = 6'd6;
    chk("t2_mem_req_valid", mem_req_valid, 1);
    chk("t2_mem_req_tag", mem_req_tag, 5);
    chk("t2_mem_req_data", mem_req_data, 32'hA5A5A5A5);
    chk("t2_outstanding", outstanding, 1);
    tick();
    chk("t2_valid_drops", mem_req_valid, 0);
    chk("t2_busy", busy, 1);

    // Stall: request held stable, no accepts, then resumes
    req_valid = 1'b1;
    req_data = 32'h11111111;
    tick();
    chk("t3_load_tag", mem_req_tag, 6);
    mem_req_stall = 1'b1;
    req_data = 32'h22222222;
    rq_index_tag = 6'd7;
    for (int i = 0; i < 3; i++) begin
      rq_full = (i == 1);
      #1;
      chk($sformatf("t3_stall_ready_%0d", i), {req_ready, rq_increment}, 2'b00);
      tick();
      chk($sformatf("t3_stall_hold_%0d", i), {mem_req_valid, mem_req_tag, mem_req_data},
          {1'b1, 6'd6, 32'h11111111});
    end
    rq_full = 1'b0;
    mem_req_stall = 1'b0;
    #1;
    chk("t3_resume_incr", rq_increment, 1);
    tick();
    req_valid = 1'b0;
    rq_index_tag = 6'd8;
    chk("t3_resume_req", {mem_req_valid, mem_req_tag, mem_req_data}, {1'b1, 6'd7, 32'h22222222});
    chk("t3_outstanding", outstanding, 3);
    rq_full = 1'b1;
    req_valid = 1'b1;
    #1;
    chk("full_blocks", req_ready, 0);
    rq_full = 1'b0;
    req_valid = 1'b0;
    tick();
`ifdef REORDER_TAGGER_ERR_EN
    chk("pre_rsp_tag_err", tag_err, 0);
`endif

    // Responses out of order: tags 3,1,2
    mem_rsp_valid = 1'b1; mem_rsp_tag = 6'd3; mem_rsp_data = 8'h33;
    #1;
    chk("t4_wr_en_not_yet", rq_wr_en, 0);
    tick();
    chk("t4_rsp0", {rq_wr_en, rq_d}, {1'b1, 14'h0CC3});
    chk("t4_out0", outstanding, 2);
    mem_rsp_tag = 6'd1; mem_rsp_data = 8'h11;
    tick();
    chk("t4_rsp1", {rq_wr_en, rq_d}, {1'b1, 14'h0441});
    mem_rsp_tag = 6'd2; mem_rsp_data = 8'h22;
    tick();
    chk("t4_rsp2", {rq_wr_en, rq_d}, {1'b1, 14'h0882});
    chk("t4_out2", outstanding, 0);
    mem_rsp_valid = 1'b0;
    tick();
    chk("t4_idle", {rq_wr_en, rq_d}, {1'b0, 14'h0882});
    chk("t4_not_busy", busy, 0);
`ifdef REORDER_TAGGER_ERR_EN
    chk("t4_tag_err_window", tag_err, 1);
`endif

    // Issue 32 with wrapping tags, no responses
    req_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      tag_v = 6'(48 + i);
      rq_index_tag = tag_v;
      req_data = i;
      #1;
      chk($sformatf("t5_incr_%0d", i), rq_increment, 1);
      tick();
      chk($sformatf("t5_tag_%0d", i), {mem_req_tag, mem_req_data}, {tag_v, 32'(i)});
    end
    rq_index_tag = 6'd16;
    chk("t5_outstanding_full", outstanding, 32);
    #1;
    chk("t5_ready_full", {req_ready, rq_increment}, 2'b00);
    mem_rsp_valid = 1'b1; mem_rsp_tag = 6'd48; mem_rsp_data = 8'h48;
    tick();
    chk("t5_after_rsp", outstanding, 31);
    mem_rsp_tag = 6'd49;
    #1;
    chk("t5_ready_again", req_ready, 1);
    tick();
    chk("t5_both_same", outstanding, 31);
    chk("t5_tag16", mem_req_tag, 16);
    mem_rsp_valid = 1'b0;
    rq_index_tag = 6'd17;
    tick();
    chk("t5_refill", outstanding, 32);
    #1;
    chk("t5_ready_blocked", req_ready, 0);

    // Mid-operation asynchronous reset discards everything
    rst = 1'b0;
    #1;
    chk("midrst_state", {mem_req_valid, outstanding, busy, req_ready}, {1'b0, 6'd0, 1'b1, 1'b0});
    tick();
    rst = 1'b1;
    req_valid = 1'b0;
`ifdef REORDER_TAGGER_ERR_EN
    chk("midrst_tag_err", tag_err, 0);
`endif
    mem_rsp_valid = 1'b1; mem_rsp_tag = 6'd9; mem_rsp_data = 8'h99;
    tick();
    mem_rsp_valid = 1'b0;
    chk("sat0_outstanding", outstanding, 0);
    chk("sat0_written", {rq_wr_en, rq_d}, {1'b1, 14'h2649});
`ifdef REORDER_TAGGER_ERR_EN
    chk("t6_tag_err_set", tag_err, 1);
    tick();
    tick();
    tick();
    chk("t6_tag_err_sticky", tag_err, 1);
`endif
    tick();
    chk("sat0_idle", rq_wr_en, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
